// File: rtl/noise_filter.sv
// Salt/pepper impulse filter: captures a packed 5x5 window, classifies the centre pixel and
// replaces a noisy centre with the floor-mean of its strictly in-range neighbours.
module noise_filter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int WINDOW_N   = 2,
   parameter int SUM_WIDTH  = 13
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [(2*WINDOW_N+1)*(2*WINDOW_N+1)*DATA_WIDTH-1:0] pack_w,
   input  logic                                           windowF,
   input  logic [ADDR_WIDTH-1:0]                          addrC,
   output logic [DATA_WIDTH-1:0]                          dataOut,
   output logic [ADDR_WIDTH-1:0]                          addrOut,
   output logic                                           outValid,
   output logic                                           noisy,
   output logic                                           busy,
   output logic                                           overrun
);

   localparam int WINDOW_W = 2*WINDOW_N + 1;
   localparam int WINDOW_S = WINDOW_W * WINDOW_W;
   localparam int CENTRE   = WINDOW_S / 2;
   localparam int CNT_W    = $clog2(WINDOW_S + 1);
   localparam int IDX_W    = $clog2(WINDOW_S + SUM_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, SCAN, CLASS, ACCUM, DIV, DONE} state_t;

   state_t state, state_nxt;

   logic                            windowF_d;
   logic                            capture;
   logic [WINDOW_S*DATA_WIDTH-1:0]  pack_r;
   logic [ADDR_WIDTH-1:0]           addr_r;
   logic [IDX_W-1:0]                idx;
   logic [DATA_WIDTH-1:0]           mn, mx, result_r;
   logic                            noisy_r;
   logic [SUM_WIDTH-1:0]            sum_r;
   logic [CNT_W-1:0]                cnt_r;
   logic [CNT_W-1:0]                rem_r;

   logic [DATA_WIDTH-1:0]           pix, centre, avg;
   logic                            last_pix, last_div, noisy_c, good;
   logic [CNT_W:0]                  rem_sh;
   logic                            ge;
   logic [CNT_W-1:0]                rem_nxt;
   logic [SUM_WIDTH-1:0]            quo_nxt;

   assign capture = windowF & ~windowF_d;

   // Per-cycle datapath terms: pixel under the scan index, classification and one divide step.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      pix      = pack_r[idx*DATA_WIDTH +: DATA_WIDTH];
      centre   = pack_r[CENTRE*DATA_WIDTH +: DATA_WIDTH];
      last_pix = (idx == IDX_W'(WINDOW_S - 1));
      last_div = (idx == IDX_W'(SUM_WIDTH - 1));
      noisy_c  = ((centre == mn) || (centre == mx)) && (mn != mx);
      good     = (pix > mn) && (pix < mx);
      avg      = DATA_WIDTH'(({1'b0, mn} + {1'b0, mx}) >> 1);
      rem_sh   = {rem_r, sum_r[SUM_WIDTH-1]};
      ge       = (rem_sh >= {1'b0, cnt_r});
      rem_nxt  = ge ? CNT_W'(rem_sh - {1'b0, cnt_r}) : rem_sh[CNT_W-1:0];
      quo_nxt  = {sum_r[SUM_WIDTH-2:0], ge};
   end

   // NOTE: state and all datapath registers update with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (capture) state_nxt = SCAN;
         SCAN:    if (last_pix) state_nxt = CLASS;
         CLASS:   state_nxt = noisy_c ? ACCUM : DONE;
         ACCUM:   if (last_pix) state_nxt = DIV;
         DIV:     if ((cnt_r == '0) || last_div) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the window store is ordinary flops, so it is reset along with everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         windowF_d <= 1'b0;
         pack_r    <= '0;
         addr_r    <= '0;
         idx       <= '0;
         mn        <= '0;
         mx        <= '0;
         result_r  <= '0;
         noisy_r   <= 1'b0;
         sum_r     <= '0;
         cnt_r     <= '0;
         rem_r     <= '0;
         dataOut   <= '0;
         addrOut   <= '0;
         outValid  <= 1'b0;
         noisy     <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         windowF_d <= windowF;
         outValid  <= (state == DONE);
         if (capture && (state != IDLE)) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (capture) begin
                  pack_r <= pack_w;
                  addr_r <= addrC;
                  idx    <= '0;
                  mn     <= '1;
                  mx     <= '0;
                  busy   <= 1'b1;
               end else begin
                  busy   <= 1'b0;
               end
            end
            SCAN: begin
               if (pix < mn) mn <= pix;
               if (pix > mx) mx <= pix;
               idx <= last_pix ? '0 : idx + IDX_W'(1);
            end
            CLASS: begin
               noisy_r  <= noisy_c;
               result_r <= centre;
               sum_r    <= '0;
               cnt_r    <= '0;
               rem_r    <= '0;
               idx      <= '0;
            end
            ACCUM: begin
               if (good) begin
                  sum_r <= sum_r + SUM_WIDTH'(pix);
                  cnt_r <= cnt_r + CNT_W'(1);
               end
               idx <= last_pix ? '0 : idx + IDX_W'(1);
            end
            DIV: begin
               // sum_r doubles as the shifting dividend/quotient register of the restoring divider
               if (cnt_r == '0) begin
                  result_r <= avg;
               end else begin
                  sum_r <= quo_nxt;
                  rem_r <= rem_nxt;
                  idx   <= idx + IDX_W'(1);
                  if (last_div) result_r <= quo_nxt[DATA_WIDTH-1:0];
               end
            end
            DONE: begin
               dataOut <= result_r;
               addrOut <= addr_r;
               noisy   <= noisy_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_noise_filter.sv
// Self-checking bench for noise_filter: directed vector table, randomized windows against a
// min/max/mean reference model, and multi-cycle sequences for overrun, reset and level-held flags.
module tb_noise_filter;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int WS    = 25;
   localparam int PW    = WS*DW;
   localparam int LIMIT = 300;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] pack_w;
   logic          windowF;
   logic [AW-1:0] addrC;
   logic [DW-1:0] dataOut;
   logic [AW-1:0] addrOut;
   logic          outValid, noisy, busy, overrun;

   int checks   = 0;
   int failures = 0;

   noise_filter dut (
      .clk      (clk),
      .rst      (rst),
      .pack_w   (pack_w),
      .windowF  (windowF),
      .addrC    (addrC),
      .dataOut  (dataOut),
      .addrOut  (addrOut),
      .outValid (outValid),
      .noisy    (noisy),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] pk;
      logic [AW-1:0] ad;
      logic [DW-1:0] d;
      logic          n;
      int            lat;
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Reference: plain min/max over the window, mean of strictly in-range pixels.
   function automatic void model(input logic [PW-1:0] pk, output logic [DW-1:0] res,
                                 output logic nz, output int lat);
      int p[WS];
      int mn = 255, mx = 0, sum = 0, cnt = 0, c;
      for (int k = 0; k < WS; k++) begin
         p[k] = int'(pk[k*DW +: DW]);
         if (p[k] < mn) mn = p[k];
         if (p[k] > mx) mx = p[k];
      end
      for (int k = 0; k < WS; k++)
         if (p[k] > mn && p[k] < mx) begin
            sum += p[k];
            cnt++;
         end
      c  = p[12];
      nz = ((c == mn) || (c == mx)) && (mn != mx);
      if (!nz)          begin res = DW'(c);             lat = 28; end
      else if (cnt == 0) begin res = DW'((mn + mx) / 2); lat = 54; end
      else              begin res = DW'(sum / cnt);      lat = 66; end
   endfunction

   function automatic logic [PW-1:0] rand_pack();
      logic [PW-1:0] pk;
      for (int k = 0; k < WS; k++)
         case ($urandom_range(0, 3))
            0:       pk[k*DW +: DW] = 8'd0;
            1:       pk[k*DW +: DW] = 8'd255;
            default: pk[k*DW +: DW] = DW'($urandom_range(0, 255));
         endcase
      return pk;
   endfunction

   // Counts cycles from the cycle windowF rises (cycle 0) to the outValid cycle; scrambles inputs
   // once the window is captured and optionally toggles windowF at given cycles.
   task automatic wait_valid(input int drop_at, input int rise_at, output int cyc);
      cyc = 0;
      @(negedge clk);
      while (outValid !== 1'b1 && cyc < LIMIT) begin
         cyc++;
         if (cyc == 2) begin
            pack_w = rand_pack();
            addrC  = AW'($urandom_range(0, 255));
         end
         if (cyc == drop_at) windowF = 1'b0;
         if (cyc == rise_at) windowF = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string nm, input int cyc, input vec_t v);
      check({nm, " latency"}, cyc, v.lat);
      check({nm, " outValid"}, outValid, 1);
      check({nm, " dataOut"}, dataOut, v.d);
      check({nm, " noisy"}, noisy, v.n);
      check({nm, " addrOut"}, addrOut, v.ad);
      check({nm, " busy"}, busy, 1);
   endtask

   task automatic run_window(input string nm, input vec_t v);
      int cyc;
      @(posedge clk); #1;
      pack_w  = v.pk;
      addrC   = v.ad;
      windowF = 1'b1;
      wait_valid(-1, -1, cyc);
      check_result(nm, cyc, v);
      windowF = 1'b0;
      @(negedge clk);
      check({nm, " pulse"}, outValid, 0);
      @(negedge clk);
      check({nm, " idle"}, busy, 0);
   endtask

   function automatic vec_t make_vec(input logic [PW-1:0] pk, input logic [AW-1:0] ad);
      vec_t v;
      v.pk = pk;
      v.ad = ad;
      model(pk, v.d, v.n, v.lat);
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v, v2;
      int   cyc, pulses;

      // Directed vectors with hand-derived expectations.
      for (int k = 0; k < WS; k++) tbl[0].pk[k*DW +: DW] = 8'd100;
      tbl[0].ad = 8'h12; tbl[0].d = 8'd100; tbl[0].n = 1'b0; tbl[0].lat = 28;
      for (int k = 0; k < WS; k++) tbl[1].pk[k*DW +: DW] = DW'(10 + k);
      tbl[1].pk[12*DW +: DW] = 8'd255;
      tbl[1].ad = 8'h34; tbl[1].d = 8'd22; tbl[1].n = 1'b1; tbl[1].lat = 66;   // 518/23
      for (int k = 0; k < WS; k++) tbl[2].pk[k*DW +: DW] = (k % 2 == 0) ? 8'd255 : 8'd0;
      tbl[2].pk[12*DW +: DW] = 8'd0;
      tbl[2].ad = 8'h56; tbl[2].d = 8'd127; tbl[2].n = 1'b1; tbl[2].lat = 54;
      for (int k = 0; k < WS; k++) tbl[3].pk[k*DW +: DW] = DW'(10 * k);
      tbl[3].ad = 8'h44; tbl[3].d = 8'd120; tbl[3].n = 1'b0; tbl[3].lat = 28;

      rst = 1'b1; windowF = 1'b0; pack_w = '0; addrC = '0;
      #1;
      check("reset dataOut", dataOut, 0);
      check("reset addrOut", addrOut, 0);
      check("reset outValid", outValid, 0);
      check("reset noisy", noisy, 0);
      check("reset busy", busy, 0);
      check("reset overrun", overrun, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_window($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 20; i++) begin
         v = make_vec(rand_pack(), AW'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) v.pk[12*DW +: DW] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
         model(v.pk, v.d, v.n, v.lat);
         run_window($sformatf("rand%0d", i), v);
      end
      check("no spurious overrun", overrun, 0);

      // Back-to-back: second capture edge in the cycle right after outValid.
      v  = tbl[3];
      v2 = tbl[0]; v2.ad = 8'h99;
      @(posedge clk); #1;
      pack_w = v.pk; addrC = v.ad; windowF = 1'b1;
      wait_valid(5, -1, cyc);
      check_result("b2b first", cyc, v);
      pack_w = v2.pk; addrC = v2.ad; windowF = 1'b1;
      wait_valid(-1, -1, cyc);
      check_result("b2b second", cyc + 1, v2);
      windowF = 1'b0;
      repeat (2) @(negedge clk);

      // Second rising edge while busy is dropped and flagged.
      v = tbl[1];
      @(posedge clk); #1;
      pack_w = v.pk; addrC = v.ad; windowF = 1'b1;
      wait_valid(5, 10, cyc);
      check_result("overrun first", cyc, v);
      check("overrun flag", overrun, 1);
      windowF = 1'b0;
      pulses = 0;
      repeat (100) begin
         @(negedge clk);
         if (outValid) pulses++;
      end
      check("overrun extra outValid", pulses, 0);

      // Asynchronous reset mid-computation.
      @(posedge clk); #1;
      pack_w = tbl[1].pk; addrC = tbl[1].ad; windowF = 1'b1;
      repeat (31) @(negedge clk);
      rst = 1'b1; windowF = 1'b0;
      #1;
      check("midrst dataOut", dataOut, 0);
      check("midrst addrOut", addrOut, 0);
      check("midrst outValid", outValid, 0);
      check("midrst noisy", noisy, 0);
      check("midrst busy", busy, 0);
      check("midrst overrun", overrun, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (80) begin
         @(negedge clk);
         if (outValid) pulses++;
      end
      check("midrst no outValid", pulses, 0);
      run_window("after rst", tbl[2]);

      // windowF held high yields exactly one result, then a fresh edge yields another.
      v = tbl[3];
      @(posedge clk); #1;
      pack_w = v.pk; addrC = v.ad; windowF = 1'b1;
      pulses = 0;
      repeat (200) begin
         @(negedge clk);
         if (outValid) pulses++;
      end
      check("held pulses", pulses, 1);
      check("held dataOut", dataOut, v.d);
      windowF = 1'b0;
      @(negedge clk);
      run_window("held second", tbl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
